ifu_fetch: RTL

- Fetch-PC stage of the IFU, directly upstream of the instruction cache. Drives the fetch address to the cache and consumes its combinational hit/inst result.
- Buffers fetched {pc, inst} pairs in a small FIFO toward decode.
- Handles backend redirects (branch or exception) and fence.i, which pulses the cache flush and refetches.

---
 rtl/ifu_fetch_if.sv | 31 +++
 rtl/ifu_fetch.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/ifu_fetch_if.sv
// Fetch-stage bus bundle: icache address/result, backend redirect/fence.i,
// decode-side FIFO head and performance counters.
interface ifu_fetch_if;
   logic [31:0] icache_addr;
   logic        icache_hit;
   logic [31:0] icache_inst;
   logic        flush_icache;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        fencei_valid;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_pc;
   logic [31:0] out_inst;
   logic [31:0] perf_miss_cycles;
   logic [31:0] perf_full_cycles;

   modport master (
      output icache_addr, flush_icache, out_valid, out_pc, out_inst,
             perf_miss_cycles, perf_full_cycles,
      input  icache_hit, icache_inst, redirect_valid, redirect_pc,
             fencei_valid, out_ready
   );

   modport slave (
      input  icache_addr, flush_icache, out_valid, out_pc, out_inst,
             perf_miss_cycles, perf_full_cycles,
      output icache_hit, icache_inst, redirect_valid, redirect_pc,
             fencei_valid, out_ready
   );
endinterface

// File: rtl/ifu_fetch.sv
// IFU fetch-PC stage: drives the icache, queues {pc, inst} toward decode,
// handles redirects and fence.i. Define IFU_PERF_EN to build the perf counters.
module ifu_fetch #(
   parameter logic [31:0] RESET_PC    = 32'h8000_0000,
   parameter int          QUEUE_DEPTH = 4
) (
   input  logic        clock,
   input  logic        reset,
   ifu_fetch_if.master bus
);
   localparam int         PW      = $clog2(QUEUE_DEPTH);
   localparam logic [PW:0] L_DEPTH = (PW+1)'(QUEUE_DEPTH);

   typedef enum logic [1:0] {
      ST_FETCH   = 2'd0,
      ST_FENCE   = 2'd1,
      ST_REFETCH = 2'd2
   } state_t;

   state_t        r_state, w_state_nxt;
   logic [29:0]   r_pc, w_pc_nxt;
   logic [PW-1:0] r_head, r_tail, w_head_nxt, w_tail_nxt;
   logic [PW:0]   r_count, w_count_nxt;
   logic [31:0]   r_mem_pc   [QUEUE_DEPTH];
   logic [31:0]   r_mem_inst [QUEUE_DEPTH];
   logic          w_full, w_push, w_pop;
   logic          w_unused_rpc_lsb;

   // Word-aligned PC only; redirect target low bits are dropped.
   assign w_unused_rpc_lsb = ^bus.redirect_pc[1:0];

   assign w_full = (r_count == L_DEPTH);
   assign w_push = (r_state == ST_FETCH) & bus.icache_hit & ~w_full
                 & ~bus.redirect_valid & ~bus.fencei_valid;
   assign w_pop  = (r_count != {(PW+1){1'b0}}) & bus.out_ready;

   // Next-state, PC and FIFO pointer computation.
   always_comb begin
      w_state_nxt = r_state;
      w_pc_nxt    = r_pc;
      w_head_nxt  = r_head;
      w_tail_nxt  = r_tail;
      w_count_nxt = r_count;
      if (bus.fencei_valid) begin
         w_state_nxt = ST_FENCE;
         w_pc_nxt    = bus.redirect_pc[31:2];
         w_head_nxt  = {PW{1'b0}};
         w_tail_nxt  = {PW{1'b0}};
         w_count_nxt = {(PW+1){1'b0}};
      end else if (bus.redirect_valid) begin
         // A redirect during the fence sequence lets the sequence finish.
         w_pc_nxt    = bus.redirect_pc[31:2];
         w_head_nxt  = {PW{1'b0}};
         w_tail_nxt  = {PW{1'b0}};
         w_count_nxt = {(PW+1){1'b0}};
         case (r_state)
            ST_FENCE: w_state_nxt = ST_REFETCH;
            default:  w_state_nxt = ST_FETCH;
         endcase
      end else begin
         case (r_state)
            ST_FENCE: w_state_nxt = ST_REFETCH;
            default:  w_state_nxt = ST_FETCH;
         endcase
         if (w_push) begin
            w_pc_nxt   = r_pc + 30'd1;
            w_tail_nxt = r_tail + PW'(1);
         end else begin
            w_pc_nxt   = r_pc;
            w_tail_nxt = r_tail;
         end
         if (w_pop) begin
            w_head_nxt = r_head + PW'(1);
         end else begin
            w_head_nxt = r_head;
         end
         case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + (PW+1)'(1);
            2'b01:   w_count_nxt = r_count - (PW+1)'(1);
            default: w_count_nxt = r_count;
         endcase
      end
   end

   // Control state register.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state <= ST_FETCH;
         r_pc    <= RESET_PC[31:2];
         r_head  <= {PW{1'b0}};
         r_tail  <= {PW{1'b0}};
         r_count <= {(PW+1){1'b0}};
      end else begin
         r_state <= w_state_nxt;
         r_pc    <= w_pc_nxt;
         r_head  <= w_head_nxt;
         r_tail  <= w_tail_nxt;
         r_count <= w_count_nxt;
      end
   end

   // FIFO storage; validity is tracked by the count, so no reset needed.
   always_ff @(posedge clock) begin
      if (w_push) begin
         r_mem_pc[r_tail]   <= {r_pc, 2'b00};
         r_mem_inst[r_tail] <= bus.icache_inst;
      end
   end

   assign bus.icache_addr  = {r_pc, 2'b00};
   assign bus.flush_icache = (r_state == ST_FENCE);
   assign bus.out_valid    = (r_count != {(PW+1){1'b0}});
   assign bus.out_pc       = r_mem_pc[r_head];
   assign bus.out_inst     = r_mem_inst[r_head];

`ifdef IFU_PERF_EN
   logic [31:0] r_perf_miss, r_perf_full;
   logic        w_miss_inc, w_full_inc;

   assign w_miss_inc = (r_state == ST_FETCH) & ~bus.icache_hit;
   assign w_full_inc = bus.icache_hit & w_full;

   // Saturating stall counters.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_perf_miss <= 32'h0;
         r_perf_full <= 32'h0;
      end else begin
         if (w_miss_inc && (r_perf_miss != 32'hFFFF_FFFF)) begin
            r_perf_miss <= r_perf_miss + 32'd1;
         end
         if (w_full_inc && (r_perf_full != 32'hFFFF_FFFF)) begin
            r_perf_full <= r_perf_full + 32'd1;
         end
      end
   end

   assign bus.perf_miss_cycles = r_perf_miss;
   assign bus.perf_full_cycles = r_perf_full;
`else
   assign bus.perf_miss_cycles = 32'h0;
   assign bus.perf_full_cycles = 32'h0;
`endif
endmodule
